// File: rtl/pipeline_controller.sv
// Main/ALU control for the five-stage MIPS core: combinational decode in D,
// with the control bundle carried through E, M and W stage registers.
module pipeline_controller #(
  parameter int OP_WIDTH     = 6,
  parameter int ALUCTL_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OP_WIDTH-1:0]     Opcode,
  input  logic [OP_WIDTH-1:0]     Funct,
  input  logic                    EqualD,
  input  logic                    FlushE,
  output logic                    BranchD,
  output logic                    JumpD,
  output logic                    PCSrcD,
  output logic                    InvalidD,
  output logic                    RegWriteE,
  output logic                    MemToRegE,
  output logic                    MemWriteE,
  output logic                    ALUSrcE,
  output logic                    RegDstE,
  output logic [ALUCTL_WIDTH-1:0] ALUControlE,
  output logic                    RegWriteM,
  output logic                    MemToRegM,
  output logic                    MemWriteM,
  output logic                    RegWriteW,
  output logic                    MemToRegW
);

  localparam int EW = 5 + ALUCTL_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

  localparam logic [OP_WIDTH-1:0] FN_ADD = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] FN_SUB = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] FN_AND = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] FN_OR  = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] FN_SLT = OP_WIDTH'(6'b101010);

  localparam logic [ALUCTL_WIDTH-1:0] ALU_ADD = ALUCTL_WIDTH'(3'b010);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_SUB = ALUCTL_WIDTH'(3'b110);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_AND = ALUCTL_WIDTH'(3'b000);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_OR  = ALUCTL_WIDTH'(3'b001);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_SLT = ALUCTL_WIDTH'(3'b111);

  logic                    dec_rw, dec_mtr, dec_mw, dec_alusrc, dec_regdst;
  logic                    dec_branch, dec_jump, dec_invalid;
  logic [ALUCTL_WIDTH-1:0] dec_alu;

  logic [EW-1:0] e_d, e_q;
  logic [2:0]    m_d, m_q;
  logic [1:0]    w_d, w_q;

  always_comb begin
    dec_rw      = 1'b0;
    dec_mtr     = 1'b0;
    dec_mw      = 1'b0;
    dec_alusrc  = 1'b0;
    dec_regdst  = 1'b0;
    dec_alu     = '0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_invalid = 1'b0;
    case (Opcode)
      OP_RTYPE: begin
        dec_rw     = 1'b1;
        dec_regdst = 1'b1;
        case (Funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: begin
            // unsupported funct collapses to the all-zero NOP bundle
            dec_invalid = 1'b1;
            dec_rw      = 1'b0;
            dec_regdst  = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        dec_rw     = 1'b1;
        dec_mtr    = 1'b1;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
      end
      OP_SW: begin
        dec_mw     = 1'b1;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu    = ALU_SUB;
      end
      OP_ADDI: begin
        dec_rw     = 1'b1;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
      end
      OP_J:    dec_jump    = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  // D-stage outputs are held low while reset is asserted
  assign BranchD  = dec_branch & reset;
  assign JumpD    = dec_jump & reset;
  assign PCSrcD   = dec_branch & EqualD & reset;
  assign InvalidD = dec_invalid & reset;

  always_comb begin
    e_d = '0;
    if (!FlushE) e_d = {dec_rw, dec_mtr, dec_mw, dec_alusrc, dec_regdst, dec_alu};
    m_d = e_q[EW-1 -: 3];
    w_d = m_q[2:1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign {RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE} = e_q;
  assign {RegWriteM, MemToRegM, MemWriteM} = m_q;
  assign {RegWriteW, MemToRegW} = w_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed vector bench for pipeline_controller: table of D inputs with expected
// D/E outputs, M/W expectations derived by shifting the expected E bundle.
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       EqualD, FlushE;
  logic       BranchD, JumpD, PCSrcD, InvalidD;
  logic       RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0] ALUControlE;
  logic       RegWriteM, MemToRegM, MemWriteM;
  logic       RegWriteW, MemToRegW;

  int checks = 0;
  int failures = 0;

  pipeline_controller #(.OP_WIDTH(6), .ALUCTL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .EqualD(EqualD), .FlushE(FlushE),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .InvalidD(InvalidD),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       eq;
    logic       flush;
    logic [3:0] exp_d;  // {Branch, Jump, PCSrc, Invalid}
    logic [7:0] exp_e;  // {RW, MTR, MW, ALUSrc, RegDst, ALU[2:0]}
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] fn, logic eq,
                              logic fl, logic [3:0] d, logic [7:0] e);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.eq = eq; v.flush = fl;
    v.exp_d = d; v.exp_e = e;
    return v;
  endfunction

  function automatic logic [3:0] act_d();
    return {BranchD, JumpD, PCSrcD, InvalidD};
  endfunction
  function automatic logic [7:0] act_e();
    return {RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE};
  endfunction
  function automatic logic [2:0] act_m();
    return {RegWriteM, MemToRegM, MemWriteM};
  endfunction
  function automatic logic [1:0] act_w();
    return {RegWriteW, MemToRegW};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_e;
  logic [2:0] exp_m;
  logic [1:0] exp_w;

  initial begin
    vecs[0]  = mk("lw",        6'b100011, 6'b000000, 1'b0, 1'b0, 4'b0000, 8'b11010010);
    vecs[1]  = mk("add",       6'b000000, 6'b100000, 1'b0, 1'b0, 4'b0000, 8'b10001010);
    vecs[2]  = mk("sub",       6'b000000, 6'b100010, 1'b0, 1'b0, 4'b0000, 8'b10001110);
    vecs[3]  = mk("and",       6'b000000, 6'b100100, 1'b0, 1'b0, 4'b0000, 8'b10001000);
    vecs[4]  = mk("or",        6'b000000, 6'b100101, 1'b0, 1'b0, 4'b0000, 8'b10001001);
    vecs[5]  = mk("slt",       6'b000000, 6'b101010, 1'b0, 1'b0, 4'b0000, 8'b10001111);
    vecs[6]  = mk("beq_ne",    6'b000100, 6'b000000, 1'b0, 1'b0, 4'b1000, 8'b00000110);
    vecs[7]  = mk("beq_eq",    6'b000100, 6'b000000, 1'b1, 1'b0, 4'b1010, 8'b00000110);
    vecs[8]  = mk("addi",      6'b001000, 6'b000000, 1'b0, 1'b0, 4'b0000, 8'b10010010);
    vecs[9]  = mk("sw_flush",  6'b101011, 6'b000000, 1'b0, 1'b1, 4'b0000, 8'b00000000);
    vecs[10] = mk("sw",        6'b101011, 6'b000000, 1'b0, 1'b0, 4'b0000, 8'b00110010);
    vecs[11] = mk("j",         6'b000010, 6'b000000, 1'b1, 1'b0, 4'b0100, 8'b00000000);
    vecs[12] = mk("bad_op",    6'b111111, 6'b000000, 1'b0, 1'b0, 4'b0001, 8'b00000000);
    vecs[13] = mk("bad_fn",    6'b000000, 6'b000111, 1'b0, 1'b0, 4'b0001, 8'b00000000);
    vecs[14] = mk("lw_flush",  6'b100011, 6'b000000, 1'b0, 1'b1, 4'b0000, 8'b00000000);
    vecs[15] = mk("addi_fl",   6'b001000, 6'b000000, 1'b0, 1'b1, 4'b0000, 8'b00000000);
    vecs[16] = mk("addi2",     6'b001000, 6'b000000, 1'b0, 1'b0, 4'b0000, 8'b10010010);

    // reset with lw already presented in D
    reset = 1'b0; Opcode = 6'b100011; Funct = 6'b0; EqualD = 1'b0; FlushE = 1'b0;
    tick(); tick();
    chk("rst_d", {4'b0, act_d()}, 8'h00);
    chk("rst_e", act_e(), 8'h00);
    chk("rst_mw", {3'b0, act_m(), act_w()}, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("rel_all", {act_d(), 4'b0} | act_e() | {3'b0, act_m(), act_w()}, 8'h00);

    exp_e = '0; exp_m = '0; exp_w = '0;
    for (int i = 0; i < 17; i++) begin
      Opcode = vecs[i].op; Funct = vecs[i].fn;
      EqualD = vecs[i].eq; FlushE = vecs[i].flush;
      #1;
      chk({vecs[i].name, "_d"}, {4'b0, act_d()}, {4'b0, vecs[i].exp_d});
      tick();
      exp_w = exp_m[2:1];
      exp_m = exp_e[7:5];
      exp_e = vecs[i].exp_e;
      chk({vecs[i].name, "_e"}, act_e(), exp_e);
      chk({vecs[i].name, "_m"}, {5'b0, act_m()}, {5'b0, exp_m});
      chk({vecs[i].name, "_w"}, {6'b0, act_w()}, {6'b0, exp_w});
    end

    // PCSrcD tracks EqualD with no clock edge in between
    Opcode = 6'b000100; Funct = 6'b0; FlushE = 1'b0; EqualD = 1'b0;
    #1 chk("pcsrc_lo", {7'b0, PCSrcD}, 8'h00);
    EqualD = 1'b1;
    #1 chk("pcsrc_hi", {7'b0, PCSrcD}, 8'h01);
    chk("branch_hi", {7'b0, BranchD}, 8'h01);

    // fill all stages with addi, then assert reset between edges
    Opcode = 6'b001000; EqualD = 1'b0;
    tick(); tick(); tick();
    chk("addi_full", {5'b0, RegWriteE, RegWriteM, RegWriteW}, 8'h07);
    #2 reset = 1'b0;
    #1;
    chk("async_rw", {5'b0, RegWriteE, RegWriteM, RegWriteW}, 8'h00);
    chk("async_e", act_e(), 8'h00);
    chk("async_d", {4'b0, act_d()}, 8'h00);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_e", act_e(), 8'b10010010);
    chk("post_rst_mw", {3'b0, act_m(), act_w()}, 8'h00);
    tick();
    chk("post_rst_m", {5'b0, act_m()}, 8'b00000100);
    chk("post_rst_w", {6'b0, act_w()}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Pipelined main/ALU control unit for the five-stage MIPS core. It decodes `Opcode`/`Funct` of the instruction in Decode and produces the Decode-stage branch/jump controls. It carries the remaining control bundle through E, M and W pipeline registers, so each stage of the datapath sees controls aligned with its own instruction. It supports an E-stage flush for hazard bubbles.

## Interface
- `OP_WIDTH`, 6, width of `Opcode` and `Funct`
- `ALUCTL_WIDTH`, 3, width of ALU control field
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; clears all stage registers
- `Opcode`  in  OP_WIDTH  instr[31:26] of the D-stage instruction
- `Funct`  in  OP_WIDTH  instr[5:0] of the D-stage instruction
- `EqualD`  in  1  D-stage register-compare result (rs == rt)
- `FlushE`  in  1  from hazard unit; loads a bubble into E
- `BranchD`, `JumpD`, `PCSrcD`  out  1 each  D-stage controls; `PCSrcD = BranchD & EqualD`
- `InvalidD`  out  1  D-stage opcode/funct not supported
- `RegWriteE`, `MemToRegE`, `MemWriteE`, `ALUSrcE`, `RegDstE`  out  1 each  E-stage controls
- `ALUControlE`  out  ALUCTL_WIDTH  E-stage ALU operation
- `RegWriteM`, `MemToRegM`, `MemWriteM`  out  1 each  M-stage controls
- `RegWriteW`, `MemToRegW`  out  1 each  W-stage controls

## Operation
- Decode is combinational. The bundle is {RegWrite, MemToReg, MemWrite, ALUSrc, RegDst, ALUControl, Branch, Jump}. Unlisted bits are 0.
  - R-type 000000: RegWrite=1, RegDst=1. Funct mapping:
    - 100000 add -> 010
    - 100010 sub -> 110
    - 100100 and -> 000
    - 100101 or -> 001
    - 101010 slt -> 111
    - Any other funct: InvalidD=1.
  - lw 100011: RegWrite, MemToReg, ALUSrc, ALU 010.
  - sw 101011: MemWrite, ALUSrc, ALU 010.
  - beq 000100: Branch, ALU 110.
  - addi 001000: RegWrite, ALUSrc, ALU 010.
  - j 000010: Jump.
  - Any other opcode: InvalidD=1.
- An invalid instruction decodes to the all-zero bundle, which is a NOP. InvalidD is informational only.
- D->E register: captures the decoded bundle each clock. If FlushE=1, it captures all zeros instead.
- E->M register: copies RegWrite, MemToReg, MemWrite each clock, with no stall or flush.
- M->W register: copies RegWrite, MemToReg each clock.
- Branch and Jump are consumed in D and are not pipelined.
- While `reset` is low:
  - All E/M/W registers are cleared asynchronously and held at 0.
  - BranchD, JumpD and PCSrcD are forced to 0.
  - InvalidD is forced to 0.

## Timing
- Reset value of every output is 0, including ALUControlE=000.
- Latency from instruction present in D:
  - D outputs: same cycle, combinational.
  - E outputs: after 1 rising edge.
  - M outputs: after 2 rising edges.
  - W outputs: after 3 rising edges.
- FlushE is sampled at the rising edge.
  - E shows zeros for exactly the next cycle.
  - That bubble reaches M one edge later and W two edges later.
  - The flushed instruction is lost. The hazard unit is responsible for re-presenting it in D.
- When FlushE coincides with a valid instruction in D, the flush wins for E. M and W still advance the prior E/M contents normally.
- Back-to-back FlushE cycles produce consecutive bubbles.
- Reset asserted mid-stream:
  - All registered outputs drop to 0 without waiting for a clock edge.
  - On deassertion, the first edge loads E from the current D decode, and M/W fill with zeros.
- PCSrcD follows EqualD combinationally within the same cycle. It is never registered.

## Test plan
- Reset low, then release. Check that all outputs are 0. Present lw (Opcode 100011) and apply 3 edges. Required:
  - After edge 1: RegWriteE=1, MemToRegE=1, ALUSrcE=1, ALUControlE=010.
  - After edge 2: RegWriteM=1, MemToRegM=1.
  - After edge 3: RegWriteW=1, MemToRegW=1.
- Stream add, sub, and, or, slt (Opcode 000000; Funct 100000/100010/100100/100101/101010) on consecutive cycles. Required: ALUControlE = 010, 110, 000, 001, 111 on consecutive cycles, with RegDstE=1 throughout.
- beq (000100) with EqualD=0, then EqualD=1 in the same cycle. Required:
  - BranchD=1 in both cases.
  - PCSrcD goes 0 then 1 combinationally.
  - Next-cycle E bundle has RegWriteE=0, MemWriteE=0, ALUControlE=110.
- sw (101011) in D with FlushE=1 at the edge. Required:
  - E bundle is all zeros for 1 cycle.
  - MemWriteM=0 on the following cycle.
  - A previously issued addi in E still reaches M with RegWriteM=1.
- Opcode 111111, and separately R-type Funct 000111. Required: InvalidD=1 and the all-zero bundle in E/M/W.
- Issue addi, then assert reset between edges. Required: RegWriteE, RegWriteM and RegWriteW go to 0 immediately, asynchronously, with no clock edge.
